result_display: RTL and testbench

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/result_display.sv | 197 +++++++++++++++++++
 tb/tb_result_display.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// result_display
// Browses a small result memory and shows the selected entry on a 4-digit,
// multiplexed 7-segment display: three decimal digits of the stored value
// plus the entry index as a hex glyph on the leftmost digit.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for enable_i; display keeps scanning old shadows
// FETCH   | one cycle: addr_display_o = idx, sample read data
// CONVERT | eight shift-add-3 steps turning the sample into BCD
// SHOW    | shadows loaded; waits for next/prev, pending or scan wrap
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-low
//   enable_i       browsing/fetch allowed while high
//   next_i/prev_i  single-cycle pulses to step the entry index
//   addr_display_o read address into the result memory
//   data_display_i read data (combinational from addr_display_o)
//   seg_o          segments gfedcba, active-low, registered
//   an_o           digit anodes, active-low one-hot, registered
//   busy_o         high in FETCH or CONVERT
module result_display #(
  parameter int REFRESH_DIV = 16,
  parameter int NUM_ENTRIES = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_i,
  input  logic       next_i,
  input  logic       prev_i,
  output logic [3:0] addr_display_o,
  input  logic [7:0] data_display_i,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, FETCH, CONVERT, SHOW} state_t;

  localparam logic [3:0]  IDX_LAST = 4'(NUM_ENTRIES - 1);
  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic        pending, pending_nxt;
  logic [7:0]  sample;
  logic [11:0] bcd, bcd_adj, bcd_step;
  logic [2:0]  bit_cnt, bit_sel;
  logic [3:0]  addr_q;
  logic [3:0]  sh_hun, sh_ten, sh_one, sh_idx;
  logic [3:0]  hun_nxt, ten_nxt, one_nxt, sidx_nxt;
  logic [15:0] div_cnt;
  logic [1:0]  digit, digit_nxt;
  logic        tick, scan_wrap, accept, load;
  logic [3:0]  code;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      default: return 7'b1111111;
    endcase
  endfunction

  // Conflicting next+prev cancel each other out.
  assign accept = enable_i & (next_i ^ prev_i);

  always_comb begin
    idx_nxt = idx;
    if (accept) begin
      if (next_i) idx_nxt = (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
      else        idx_nxt = (idx == 4'd0) ? IDX_LAST : idx - 4'd1;
    end
  end

  // Double-dabble step: adjust nibbles, then shift in the next sample bit (MSB first).
  assign bit_sel  = 3'd7 - bit_cnt;
  assign bcd_adj  = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  assign bcd_step = {bcd_adj[10:0], sample[bit_sel]};

  assign tick      = (div_cnt == DIV_LAST);
  assign scan_wrap = tick && (digit == 2'd3);
  assign digit_nxt = tick ? digit + 2'd1 : digit;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_nxt   = FETCH;
          pending_nxt = 1'b0;
        end
      end
      FETCH: begin
        state_nxt = CONVERT;
        if (accept) pending_nxt = 1'b1;
      end
      CONVERT: begin
        if (accept) pending_nxt = 1'b1;
        if (bit_cnt == 3'd7) begin
          state_nxt = SHOW;
          load      = 1'b1;
        end
      end
      SHOW: begin
        if (accept || pending || scan_wrap) begin
          state_nxt   = FETCH;
          pending_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Losing enable abandons whatever is in flight; shadows keep their value.
    if (!enable_i) begin
      state_nxt = IDLE;
      load      = 1'b0;
    end
  end

  assign hun_nxt  = load ? bcd_step[11:8] : sh_hun;
  assign ten_nxt  = load ? bcd_step[7:4]  : sh_ten;
  assign one_nxt  = load ? bcd_step[3:0]  : sh_one;
  assign sidx_nxt = load ? idx            : sh_idx;

  always_comb begin
    case (digit_nxt)
      2'd0:    code = one_nxt;
      2'd1:    code = ten_nxt;
      2'd2:    code = hun_nxt;
      default: code = sidx_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= 4'd0;
      pending <= 1'b0;
      sample  <= 8'd0;
      bcd     <= 12'd0;
      bit_cnt <= 3'd0;
      addr_q  <= 4'd0;
      sh_hun  <= 4'd0;
      sh_ten  <= 4'd0;
      sh_one  <= 4'd0;
      sh_idx  <= 4'd0;
      div_cnt <= 16'd0;
      digit   <= 2'd0;
      seg_o   <= 7'b1111111;
      an_o    <= 4'b1111;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      pending <= pending_nxt;
      if (state == FETCH) begin
        sample  <= data_display_i;
        addr_q  <= idx;
        bcd     <= 12'd0;
        bit_cnt <= 3'd0;
      end else if (state == CONVERT) begin
        bcd     <= bcd_step;
        bit_cnt <= bit_cnt + 3'd1;
      end
      sh_hun  <= hun_nxt;
      sh_ten  <= ten_nxt;
      sh_one  <= one_nxt;
      sh_idx  <= sidx_nxt;
      div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
      digit   <= digit_nxt;
      if (tick || load) begin
        an_o  <= ~(4'b0001 << digit_nxt);
        seg_o <= glyph(code);
      end
    end
  end

  assign addr_display_o = (state == FETCH) ? idx : addr_q;
  assign busy_o         = (state == FETCH) || (state == CONVERT);

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;
  localparam int RD = 4;
  localparam int NE = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable_i = 1'b0;
  logic       next_i = 1'b0;
  logic       prev_i = 1'b0;
  logic [3:0] addr_display_o;
  logic [7:0] data_display_i;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic       busy_o;

  logic [7:0] mem [16];
  logic [6:0] sb [$];
  int n_checks = 0;
  int n_pass = 0;

  result_display #(.REFRESH_DIV(RD), .NUM_ENTRIES(NE)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .next_i(next_i),
    .prev_i(prev_i), .addr_display_o(addr_display_o),
    .data_display_i(data_display_i), .seg_o(seg_o), .an_o(an_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  assign data_display_i = mem[addr_display_o];

  typedef struct {
    logic [7:0] data;
    int hun;
    int ten;
    int one;
  } vec_t;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0001000; 11: return 7'b0000011;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic level, input int budget, input string name);
    int c;
    c = 0;
    while (busy_o !== level && c < budget) begin
      step();
      c++;
    end
    if (busy_o !== level) check(name, 32'(busy_o), 32'(level));
  endtask

  task automatic pulse(input logic nx, input logic pv);
    next_i = nx;
    prev_i = pv;
    step();
    next_i = 1'b0;
    prev_i = 1'b0;
  endtask

  task automatic capture(output logic [6:0] g0, output logic [6:0] g1,
                         output logic [6:0] g2, output logic [6:0] g3);
    g0 = 7'h55; g1 = 7'h55; g2 = 7'h55; g3 = 7'h55;
    for (int c = 0; c < 4 * RD + 4; c++) begin
      step();
      case (an_o)
        4'b1110: g0 = seg_o;
        4'b1101: g1 = seg_o;
        4'b1011: g2 = seg_o;
        4'b0111: g3 = seg_o;
        default: ;
      endcase
    end
  endtask

  task automatic expect_display(input int hun, input int ten, input int one, input int id);
    sb.push_back(glyph(one));
    sb.push_back(glyph(ten));
    sb.push_back(glyph(hun));
    sb.push_back(glyph(id));
  endtask

  task automatic compare_display(input string name);
    logic [6:0] g [4];
    logic [6:0] e;
    capture(g[0], g[1], g[2], g[3]);
    for (int d = 0; d < 4; d++) begin
      if (sb.size() == 0) begin
        check({name, "_sb_empty"}, 32'(0), 32'(1));
      end else begin
        e = sb.pop_front();
        check($sformatf("%s_digit%0d", name, d), 32'(g[d]), 32'(e));
      end
    end
  endtask

  initial begin
    vec_t vecs [8];
    int   cnt;
    int   exp_idx;
    logic [3:0] an_prev;
    logic [3:0] exp_an;
    logic [6:0] exp_seg [4];

    vecs[0] = '{8'd0,   0, 0, 0};
    vecs[1] = '{8'd7,   0, 0, 7};
    vecs[2] = '{8'd42,  0, 4, 2};
    vecs[3] = '{8'd99,  0, 9, 9};
    vecs[4] = '{8'd100, 1, 0, 0};
    vecs[5] = '{8'd128, 1, 2, 8};
    vecs[6] = '{8'd200, 2, 0, 0};
    vecs[7] = '{8'd254, 2, 5, 4};

    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 20 + 3);
    mem[0] = 8'd255;

    // Reset state
    step(); step();
    check("rst_seg", 32'(seg_o), 32'h7f);
    check("rst_an", 32'(an_o), 32'hf);
    check("rst_addr", 32'(addr_display_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);

    // First fetch of 255
    reset = 1'b1;
    step();
    enable_i = 1'b1;
    wait_busy(1'b1, 5, "first_fetch_timeout");
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 20) begin
      cnt++;
      step();
    end
    check("busy_len", 32'(cnt), 32'd9);
    expect_display(2, 5, 5, 0);
    repeat (30) step();
    compare_display("show255");

    // Table of conversions at entry 0
    foreach (vecs[i]) begin
      mem[0] = vecs[i].data;
      expect_display(vecs[i].hun, vecs[i].ten, vecs[i].one, 0);
      repeat (40) step();
      compare_display($sformatf("vec%0d", i));
    end

    // Scan order and timing with 123
    mem[0] = 8'd123;
    repeat (40) step();
    exp_seg[0] = glyph(3); exp_seg[1] = glyph(2);
    exp_seg[2] = glyph(1); exp_seg[3] = glyph(0);
    an_prev = an_o;
    cnt = 0;
    step();
    while (!(an_o == 4'b1110 && an_prev == 4'b0111) && cnt < 40) begin
      an_prev = an_o;
      step();
      cnt++;
    end
    for (int k = 0; k < 4 * RD; k++) begin
      exp_an = ~(4'b0001 << (k / RD));
      check($sformatf("scan_an%0d", k), 32'(an_o), 32'(exp_an));
      check($sformatf("scan_seg%0d", k), 32'(seg_o), 32'(exp_seg[k / RD]));
      step();
    end

    // Simultaneous next+prev in SHOW: no fetch, idx unchanged
    wait_busy(1'b1, 40, "sim_wait_fetch");
    wait_busy(1'b0, 20, "sim_wait_show");
    pulse(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sim_nofetch%0d", k), 32'(busy_o), 32'h0);
      step();
    end
    check("sim_addr", 32'(addr_display_o), 32'h0);

    // Pulses while disabled are ignored
    enable_i = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      pulse(1'b1, 1'b0);
      step();
    end
    check("dis_busy", 32'(busy_o), 32'h0);
    enable_i = 1'b1;
    repeat (30) step();
    check("dis_addr", 32'(addr_display_o), 32'h0);

    // Twelve next pulses wrap the index, then one prev wraps back
    exp_idx = 0;
    for (int p = 0; p < NE; p++) begin
      pulse(1'b1, 1'b0);
      exp_idx = (exp_idx + 1) % NE;
      repeat (19) step();
      check($sformatf("next%0d_addr", p), 32'(addr_display_o), 32'(exp_idx));
    end
    pulse(1'b0, 1'b1);
    exp_idx = (exp_idx == 0) ? NE - 1 : exp_idx - 1;
    wait_busy(1'b0, 20, "prev_wait_idle");
    wait_busy(1'b1, 30, "prev_wait_fetch");
    check("prev_fetch_addr", 32'(addr_display_o), 32'(exp_idx));
    expect_display(mem[11] / 100, (mem[11] / 10) % 10, mem[11] % 10, 11);
    repeat (30) step();
    compare_display("prev11");

    // next during CONVERT cycle 3: stale SHOW, then an immediate refetch
    mem[11] = 8'd45;
    mem[0]  = 8'd222;
    wait_busy(1'b0, 20, "cv_wait_idle");
    wait_busy(1'b1, 30, "cv_wait_fetch");
    step(); step(); step();
    pulse(1'b1, 1'b0);
    wait_busy(1'b0, 12, "cv_wait_show");
    cnt = 0;
    while (busy_o !== 1'b1 && cnt < 20) begin
      cnt++;
      step();
    end
    check("cv_show_len", 32'(cnt), 32'd1);
    check("cv_refetch_addr", 32'(addr_display_o), 32'd0);
    expect_display(2, 2, 2, 0);
    repeat (20) step();
    compare_display("cv222");

    // Reset in the middle of a conversion
    mem[0] = 8'd99;
    wait_busy(1'b0, 20, "rc_wait_idle");
    wait_busy(1'b1, 30, "rc_wait_fetch");
    step(); step();
    reset = 1'b0;
    #1;
    check("rc_seg", 32'(seg_o), 32'h7f);
    check("rc_an", 32'(an_o), 32'hf);
    check("rc_addr", 32'(addr_display_o), 32'h0);
    check("rc_busy", 32'(busy_o), 32'h0);
    step();
    reset = 1'b1;
    expect_display(0, 9, 9, 0);
    repeat (40) step();
    compare_display("rc99");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
